// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: shifter states, register map, status layout.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Shifter states; the encoding is fixed so it can be read out in debug views.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Register offsets selected by the single address bit.
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // Bit positions inside the STATUS register.
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;

    // Build the STATUS byte; unused upper bits read as zero.
    function automatic logic [7:0] pack_status(input logic full,
                                               input logic empty,
                                               input logic busy);
        logic [7:0] s;
        s             = '0;
        s[STAT_FULL]  = full;
        s[STAT_EMPTY] = empty;
        s[STAT_BUSY]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU bus slave port of the UART: read/write request with one-cycle ready pulses.
// Latency: ready_r / ready_w arrive one cycle after the request is sampled.
// Backpressure: the slave withholds ready_w while it cannot take a write.
interface uart_tx_if;
    logic       read;
    logic       write;
    logic       ready_r;
    logic       ready_w;
    logic       address;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output read, write, address, data_in,
        input  ready_r, ready_w, data_out
    );

    modport slave (
        input  read, write, address, data_in,
        output ready_r, ready_w, data_out
    );
endinterface

// File: rtl/fifo_sync.sv
// Synchronous FIFO with extra-MSB pointers; head entry visible combinationally on dout.
// Latency: a pushed entry is visible on dout the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module fifo_sync #(
    parameter int width     = 8,
    parameter int size_addr = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << size_addr;

    logic [width-1:0] mem [DEPTH];
    logic [size_addr:0] wr_ptr;
    logic [size_addr:0] rd_ptr;
    logic do_push;
    logic do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[size_addr] != rd_ptr[size_addr]) &&
                   (wr_ptr[size_addr-1:0] == rd_ptr[size_addr-1:0]);

    // A pop on the same edge frees the slot being written, so a full FIFO still accepts.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[size_addr-1:0]];

    // Pointer update; reset clears the FIFO by equalising the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[size_addr-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Bus-mapped 8N1 UART transmitter: bytes written to DATA are queued and sent LSB first.
// Latency: ready_w/ready_r one cycle after the request; tx falls one cycle after the push.
// Backpressure: a DATA write with the FIFO full waits (no ready_w) until the shifter pops.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int clk_div   = 16,
    parameter int fifo_addr = 2
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx
);

    localparam int CW = $clog2(clk_div);
    localparam logic [CW-1:0] BAUD_LAST = CW'(clk_div - 1);

    // FIFO side
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    // Shifter state and next-state
    tx_state_t       state,   state_nxt;
    logic [CW-1:0]   cnt,     cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg,   shreg_nxt;
    logic            tx_q,    tx_nxt;
    logic            baud_done;
    logic            busy;

    // Bus decode
    logic bus_idle;
    logic wr_req;
    logic rd_req;
    logic wr_data;
    logic push_ok;

    // A request is only looked at when no ready pulse is outstanding, which
    // prevents accepting the same request twice while the master drops it.
    assign bus_idle = !(bus.ready_r || bus.ready_w);
    assign wr_req   = bus_idle && bus.write;
    assign rd_req   = bus_idle && bus.read && !bus.write;
    assign wr_data  = wr_req && (bus.address == REG_DATA);

    // A full FIFO still takes the byte if the shifter pops on the same edge.
    assign push_ok   = !fifo_full || fifo_pop;
    assign fifo_push = wr_data && push_ok;

    assign busy      = (state != S_IDLE);
    assign baud_done = (cnt == BAUD_LAST);
    assign tx        = tx_q;

    fifo_sync #(
        .width     (8),
        .size_addr (fifo_addr)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus responses: one-cycle ready pulses; data_out holds the last read value.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ready_r  <= 1'b0;
            bus.ready_w  <= 1'b0;
            bus.data_out <= 8'h00;
        end else begin
            bus.ready_r <= 1'b0;
            bus.ready_w <= 1'b0;
            if (wr_req) begin
                // STATUS writes are dropped but still acknowledged so the CPU moves on.
                if (bus.address == REG_STATUS || push_ok) begin
                    bus.ready_w <= 1'b1;
                end
            end else if (rd_req) begin
                bus.ready_r  <= 1'b1;
                bus.data_out <= (bus.address == REG_STATUS)
                                ? pack_status(fifo_full, fifo_empty, busy)
                                : 8'h00;
            end
        end
    end

    // Shifter state register; reset forces the line idle and drops any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            tx_q    <= tx_nxt;
        end
    end

    // Shifter next-state: each state lasts clk_div cycles; the counter restarts
    // at every bit boundary so a STOP->START hand-off leaves no idle gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        tx_nxt    = tx_q;
        fifo_pop  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                tx_nxt  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_dout;
                    tx_nxt    = 1'b0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    cnt_nxt   = '0;
                    bit_nxt   = 3'd0;
                    tx_nxt    = shreg[0];
                    state_nxt = S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        // Shift out the bit just sent; the next one is shreg[1].
                        bit_nxt   = bit_idx + 3'd1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                        tx_nxt    = shreg[1];
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    cnt_nxt = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shreg_nxt = fifo_dout;
                        tx_nxt    = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
